// File: rtl/add_req_scheduler.sv
// Round-robin scheduler: shares one pipelined adder among NUM_REQ requesters,
// tags each issue with its requester ID and collects results in a response FIFO.
// Credit (outstanding ops <= RSP_DEPTH) guarantees the FIFO never overflows.
// The credit check uses the registered outstanding count, so a pop frees a slot
// one cycle later.
module add_req_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ADD_LATENCY = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          add_en,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  input  logic [DATA_WIDTH:0]           add_sum,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH:0]           rsp_sum,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic                          busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int ENT_W = DATA_WIDTH + 1 + ID_W;

  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       winner;
  logic [ID_W-1:0]       cand;
  logic [ID_W-1:0]       issue_id;
  logic [ID_W-1:0]       cap_id;
  logic                  grant;
  logic                  accept;
  logic                  cap_v;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [ENT_W-1:0]      fifo_mem [RSP_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin search from last_grant+1, gated by credit; also selects winner operands
  always_comb begin
    grant     = 1'b0;
    winner    = '0;
    cand      = '0;
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    if (rst && (outstanding < CNT_W'(RSP_DEPTH))) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
        if (!grant && req_valid[cand]) begin
          grant  = 1'b1;
          winner = cand;
        end
      end
    end
    if (grant) req_ready[winner] = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept = grant;

  // Priority pointer advances only on an accepted request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant <= ID_W'(NUM_REQ - 1);
    else if (accept) last_grant <= winner;
  end

  // Issue register: operands held when nothing is issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_en   <= 1'b0;
      add_a    <= '0;
      add_b    <= '0;
      issue_id <= '0;
    end else begin
      add_en <= accept;
      if (accept) begin
        add_a    <= sel_a;
        add_b    <= sel_b;
        issue_id <= winner;
      end
    end
  end

  generate
    if (ADD_LATENCY == 0) begin : g_comb_adder
      assign cap_v  = add_en;
      assign cap_id = issue_id;
    end else begin : g_tag_pipe
      logic [ADD_LATENCY-1:0] pipe_v;
      logic [ID_W-1:0]        pipe_id [ADD_LATENCY];

      // Tag/valid shift register tracking the adder pipeline
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pipe_v <= '0;
          for (int i = 0; i < ADD_LATENCY; i++) pipe_id[i] <= '0;
        end else begin
          pipe_v[0]  <= add_en;
          pipe_id[0] <= issue_id;
          for (int i = 1; i < ADD_LATENCY; i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_id[i] <= pipe_id[i-1];
          end
        end
      end

      assign cap_v  = pipe_v[ADD_LATENCY-1];
      assign cap_id = pipe_id[ADD_LATENCY-1];
    end
  endgenerate

  assign push  = cap_v;
  assign empty = (fifo_cnt == '0);
  assign full  = (fifo_cnt == CNT_W'(RSP_DEPTH));
  assign pop   = rsp_valid & rsp_ready;

  // Outstanding ops: issued but not yet popped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) outstanding <= '0;
    else if (accept && !pop) outstanding <= outstanding + CNT_W'(1);
    else if (!accept && pop) outstanding <= outstanding - CNT_W'(1);
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (!push && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {add_sum, cap_id};
  end

  assign rsp_valid         = !empty;
  assign {rsp_sum, rsp_id} = empty ? '0 : fifo_mem[rd_ptr];
  assign busy              = (outstanding != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

endmodule
